// File: rtl/div_if.sv
// Handshake and operand bundle between the EX stage and the radix-2 divider.
// The master drives the request side and the slave returns status and the {hi,lo} result.
interface div_if #(
    parameter int WIDTH = 32
) ();
    logic               start;
    logic               signed_div;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               cancel;
    logic               busy;
    logic               ready;
    logic [2*WIDTH-1:0] result;

    modport master (
        output start, signed_div, a, b, cancel,
        input  busy, ready, result
    );

    modport slave (
        input  start, signed_div, a, b, cancel,
        output busy, ready, result
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; result = {hi=remainder, lo=quotient}.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips CALC and completes one cycle after start.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    div_if.slave     bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_div;
    logic               r_qneg;
    logic               r_rneg;
    logic               r_bzero;
    logic               r_busy;
    logic               r_ready;
    logic [2*WIDTH-1:0] r_result;

    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH-1:0]   w_rem_nx;
    logic [WIDTH-1:0]   w_quo_nx;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic               w_a_neg;
    logic               w_b_neg;

    assign bus.busy   = r_busy;
    assign bus.ready  = r_ready;
    assign bus.result = r_result;

    // One restoring iteration plus the sign fixups applied on the final step.
    always_comb begin
        w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
        w_trial   = w_rem_sh - {1'b0, r_div};
        w_quo_nx  = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
        if (w_trial[WIDTH]) begin
            w_rem_nx = w_rem_sh[WIDTH-1:0];
        end else begin
            w_rem_nx = w_trial[WIDTH-1:0];
        end
        if (r_qneg) begin
            w_quo_fix = -w_quo_nx;
        end else begin
            w_quo_fix = w_quo_nx;
        end
        if (r_rneg) begin
            w_rem_fix = -w_rem_nx;
        end else begin
            w_rem_fix = w_rem_nx;
        end
        w_a_neg = bus.signed_div & bus.a[WIDTH-1];
        w_b_neg = bus.signed_div & bus.b[WIDTH-1];
    end

    // Divider FSM with registered busy/ready/result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= {CW{1'b0}};
            r_rem    <= {WIDTH{1'b0}};
            r_quo    <= {WIDTH{1'b0}};
            r_div    <= {WIDTH{1'b0}};
            r_qneg   <= 1'b0;
            r_rneg   <= 1'b0;
            r_bzero  <= 1'b0;
            r_busy   <= 1'b0;
            r_ready  <= 1'b0;
            r_result <= {(2*WIDTH){1'b0}};
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (bus.cancel) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b0;
                    end else if (bus.start) begin
                        r_quo   <= w_a_neg ? -bus.a : bus.a;
                        r_div   <= w_b_neg ? -bus.b : bus.b;
                        r_qneg  <= w_a_neg ^ w_b_neg;
                        r_rneg  <= w_a_neg;
                        r_bzero <= (bus.b == {WIDTH{1'b0}});
                        r_rem   <= {WIDTH{1'b0}};
                        r_cnt   <= {CW{1'b0}};
`ifdef DIV_ZERO_FAST_EN
                        if (bus.b == {WIDTH{1'b0}}) begin
                            r_state  <= DONE;
                            r_busy   <= 1'b0;
                            r_ready  <= 1'b1;
                            r_result <= {bus.a, {WIDTH{1'b1}}};
                        end else begin
                            r_state <= CALC;
                            r_busy  <= 1'b1;
                            r_ready <= 1'b0;
                        end
`else
                        r_state <= CALC;
                        r_busy  <= 1'b1;
                        r_ready <= 1'b0;
`endif
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b0;
                    end
                end
                CALC: begin
                    if (bus.cancel) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b0;
                    end else begin
                        r_rem <= w_rem_nx;
                        r_quo <= w_quo_nx;
                        r_cnt <= r_cnt + CW'(1);
                        // Result is registered on the last iteration so it is valid throughout DONE.
                        if (r_cnt == CW'(WIDTH - 1)) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_ready <= 1'b1;
                            if (r_bzero) begin
                                r_result <= {w_rem_fix, {WIDTH{1'b1}}};
                            end else begin
                                r_result <= {w_rem_fix, w_quo_fix};
                            end
                        end else begin
                            r_state <= CALC;
                            r_busy  <= 1'b1;
                            r_ready <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: latency, signed/unsigned results, divide-by-zero,
// cancel, asynchronous reset and back-to-back issue.
module tb_div_unit;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    div_if #(.WIDTH(32)) u_if ();

    div_unit #(.WIDTH(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT  = 1;
    localparam int ZBUSY = 0;
`else
    localparam int ZLAT  = 33;
    localparam int ZBUSY = 32;
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive a request in the current cycle (caller sits at a negedge).
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        u_if.start      = 1'b1;
        u_if.a          = a;
        u_if.b          = b;
        u_if.signed_div = sgn;
    endtask

    // Wait for ready, counting cycles and busy cycles; returns at the negedge of the ready cycle.
    task automatic wait_result(input string tag, input int exp_lat, input int exp_busy,
                               input logic [63:0] exp_res);
        int lat;
        int nbusy;
        lat   = 0;
        nbusy = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                u_if.start = 1'b0;
                u_if.a     = 32'hDEAD_BEEF;
                u_if.b     = 32'h0000_0001;
            end
            if (u_if.busy) nbusy++;
        end while (!u_if.ready && lat < 40);
        check({tag, "_lat"},  64'(lat),   64'(exp_lat));
        check({tag, "_busy"}, 64'(nbusy), 64'(exp_busy));
        check({tag, "_res"},  u_if.result, exp_res);
    endtask

    initial begin
        int  seen_ready;
        n_checks        = 0;
        n_errors        = 0;
        rst             = 1'b1;
        u_if.start      = 1'b0;
        u_if.signed_div = 1'b0;
        u_if.a          = 32'h0;
        u_if.b          = 32'h0;
        u_if.cancel     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",   64'(u_if.busy),  64'h0);
        check("rst_ready",  64'(u_if.ready), 64'h0);
        check("rst_result", u_if.result,     64'h0);
        rst = 1'b0;
        @(negedge clk);

        launch(32'd100, 32'd7, 1'b0);
        wait_result("divu_100_7", 33, 32, {32'd2, 32'd14});
        @(negedge clk);
        check("ready_pulse", 64'(u_if.ready), 64'h0);
        check("result_hold", u_if.result, {32'd2, 32'd14});

        launch(32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_result("div_m7_2", 33, 32, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        @(negedge clk);
        launch(32'd7, 32'hFFFF_FFFE, 1'b1);
        wait_result("div_7_m2", 33, 32, {32'h0000_0001, 32'hFFFF_FFFD});
        @(negedge clk);
        launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_result("div_wrap", 33, 32, {32'h0, 32'h8000_0000});
        @(negedge clk);
        launch(32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
        wait_result("divu_big", 33, 32, {32'h7FFF_FFFF, 32'h1});
        @(negedge clk);
        launch(32'h0000_1234, 32'h0, 1'b0);
        wait_result("divu_zero", ZLAT, ZBUSY, {32'h0000_1234, 32'hFFFF_FFFF});
        @(negedge clk);
        launch(32'hFFFF_FFF9, 32'h0, 1'b1);
        wait_result("div_zero_neg", ZLAT, ZBUSY, {32'hFFFF_FFF9, 32'hFFFF_FFFF});
        @(negedge clk);

        // Cancel in cycle 10: no ready, result keeps the divide-by-zero value.
        launch(32'd100, 32'd7, 1'b0);
        repeat (10) begin
            @(negedge clk);
            u_if.start = 1'b0;
        end
        u_if.cancel = 1'b1;
        u_if.start  = 1'b1;
        @(negedge clk);
        u_if.cancel = 1'b0;
        u_if.start  = 1'b0;
        check("cancel_busy",  64'(u_if.busy),  64'h0);
        check("cancel_ready", 64'(u_if.ready), 64'h0);
        seen_ready = 0;
        repeat (40) begin
            @(negedge clk);
            if (u_if.ready) seen_ready++;
        end
        check("cancel_no_ready", 64'(seen_ready), 64'h0);
        check("cancel_result",   u_if.result, {32'hFFFF_FFF9, 32'hFFFF_FFFF});
        launch(32'd9, 32'd3, 1'b0);
        wait_result("after_cancel", 33, 32, {32'd0, 32'd3});

        // Back-to-back: the next start is issued in the ready cycle.
        launch(32'd1000, 32'd33, 1'b0);
        wait_result("b2b_1", 33, 32, {32'd10, 32'd30});
        launch(32'hFFFF_FF9C, 32'd7, 1'b1);
        wait_result("b2b_2", 33, 32, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
        @(negedge clk);

        // Asynchronous reset in cycle 15 of a CALC.
        launch(32'd100, 32'd7, 1'b0);
        repeat (15) begin
            @(negedge clk);
            u_if.start = 1'b0;
        end
        check("mid_busy", 64'(u_if.busy), 64'h1);
        #1 rst = 1'b1;
        #1;
        check("arst_busy",   64'(u_if.busy),  64'h0);
        check("arst_ready",  64'(u_if.ready), 64'h0);
        check("arst_result", u_if.result,     64'h0);
        @(negedge clk);
        rst = 1'b0;
        seen_ready = 0;
        repeat (40) begin
            @(negedge clk);
            if (u_if.ready) seen_ready++;
        end
        check("arst_no_ready", 64'(seen_ready), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
